jtag_frame_loader: RTL

- Parametrised loader that assembles a frame of `IMAGE_BITS` bits from a JTAG-mailbox register bank. The bank holds `WORDS_PER_CHUNK` × `WORD_W` bits and is delivered in successive chunks.
- The host writes one chunk into the bank and raises `iNEXT`; the last chunk is flagged with `iFINISH`.
- The block double-buffers the frame, commits it to the network only when the network is idle, and pulses `oSTART`.
- It sits between the JTAG register bank and `run_network`.

---
 rtl/jtag_frame_loader_if.sv | 37 +++
 rtl/jtag_frame_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/jtag_frame_loader_if.sv
// jtag_frame_loader_if
//   Bundles the mailbox-side and network-side signals of jtag_frame_loader.
//   Parameters mirror the loader so that widths agree at both ends.
//   Modports:
//     master : host/network side (drives iDATA, iNEXT, iFINISH, iBUSY, iCLR_ERR;
//              observes oIMAGE, oSTART, oCHUNK_IDX, oPENDING, oOVERRUN)
//     slave  : loader side (the reverse)
interface jtag_frame_loader_if #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_CHUNK = 14,
  parameter int IMAGE_BITS      = 784
);
  localparam int CHUNK_BITS = WORD_W * WORDS_PER_CHUNK;
  localparam int NCHUNK     = (IMAGE_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int CIDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [CHUNK_BITS-1:0] iDATA;
  logic                  iNEXT;
  logic                  iFINISH;
  logic                  iBUSY;
  logic                  iCLR_ERR;
  logic [IMAGE_BITS-1:0] oIMAGE;
  logic                  oSTART;
  logic [CIDX_W-1:0]     oCHUNK_IDX;
  logic                  oPENDING;
  logic                  oOVERRUN;

  modport master (
    output iDATA, iNEXT, iFINISH, iBUSY, iCLR_ERR,
    input  oIMAGE, oSTART, oCHUNK_IDX, oPENDING, oOVERRUN
  );

  modport slave (
    input  iDATA, iNEXT, iFINISH, iBUSY, iCLR_ERR,
    output oIMAGE, oSTART, oCHUNK_IDX, oPENDING, oOVERRUN
  );
endinterface

// File: rtl/jtag_frame_loader.sv
// jtag_frame_loader
//   Assembles an IMAGE_BITS frame from successive chunks of a JTAG mailbox
//   register bank into a shadow buffer, then commits it to oIMAGE (with a
//   one-cycle oSTART strobe) once the network reports idle.
//   Ports:
//     iCLK    : clock, all state on rising edge
//     iRESETn : asynchronous active-low reset
//     mbox    : jtag_frame_loader_if.slave
//               iDATA/iNEXT/iFINISH  chunk data, chunk-valid level, last-chunk flag
//               iBUSY/iCLR_ERR       network busy, overrun clear
//               oIMAGE/oSTART        committed frame and its update strobe
//               oCHUNK_IDX/oPENDING  next chunk expected, frame waiting for idle
//               oOVERRUN             sticky: chunk arrived while pending
//   Build option: define LOADER_SYNC_EN to pass iNEXT/iFINISH through 2-flop
//   synchronisers (host writing from the TCK domain). Undefined: used directly.
module jtag_frame_loader #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_CHUNK = 14,
  parameter int IMAGE_BITS      = 784
) (
  input  logic                iCLK,
  input  logic                iRESETn,
  jtag_frame_loader_if.slave  mbox
);
  localparam int CHUNK_BITS = WORD_W * WORDS_PER_CHUNK;
  localparam int NCHUNK     = (IMAGE_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int CIDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NCHUNK - 1);

  typedef enum logic {LOAD, PEND} state_t;

  state_t                state_q, state_d;
  logic                  nxt_s, fin_s, settled;
  logic                  nxt_d, armed, rise;
  logic                  load_en, commit, ovr_set;
  logic [IMAGE_BITS-1:0] shadow, image_q;
  logic [CIDX_W-1:0]     idx_q;
  logic                  start_q, overrun_q;

`ifdef LOADER_SYNC_EN
  logic       nxt_m, fin_m;
  logic [1:0] warm;

  // Synchroniser stage; warm marks when the sync chain reflects post-reset input
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      nxt_m <= 1'b0;
      nxt_s <= 1'b0;
      fin_m <= 1'b0;
      fin_s <= 1'b0;
      warm  <= 2'b00;
    end else begin
      nxt_m <= mbox.iNEXT;
      nxt_s <= nxt_m;
      fin_m <= mbox.iFINISH;
      fin_s <= fin_m;
      warm  <= {warm[0], 1'b1};
    end
  end
  assign settled = warm[1];
`else
  assign nxt_s   = mbox.iNEXT;
  assign fin_s   = mbox.iFINISH;
  assign settled = 1'b1;
`endif

  // Edge-detect stage. armed blocks a level that was already high when reset
  // released from looking like a rise: it must first be seen low.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      nxt_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      nxt_d <= nxt_s;
      if (settled && !nxt_s) armed <= 1'b1;
    end
  end
  assign rise = nxt_s & ~nxt_d & armed;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) state_q <= LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    commit  = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      LOAD: begin
        if (rise) begin
          load_en = 1'b1;
          if (fin_s || (idx_q == LAST_IDX)) state_d = PEND;
        end
      end
      PEND: begin
        // A rise here (including on the commit edge) is dropped as an overrun
        if (rise) ovr_set = 1'b1;
        if (!mbox.iBUSY) begin
          commit  = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Capture / commit stage
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      shadow    <= '0;
      image_q   <= '0;
      idx_q     <= '0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      start_q <= commit;
      if (commit) begin
        image_q <= shadow;
        shadow  <= '0;
      end else if (load_en) begin
        // Bit i belongs to chunk i/CHUNK_BITS; bits past IMAGE_BITS never exist
        for (int i = 0; i < IMAGE_BITS; i++) begin
          if (int'(idx_q) == i / CHUNK_BITS) shadow[i] <= mbox.iDATA[i % CHUNK_BITS];
        end
      end
      if (load_en) begin
        if (state_d == PEND) idx_q <= '0;
        else                 idx_q <= idx_q + 1'b1;
      end
      if (ovr_set)            overrun_q <= 1'b1;
      else if (mbox.iCLR_ERR) overrun_q <= 1'b0;
    end
  end

  assign mbox.oIMAGE     = image_q;
  assign mbox.oSTART     = start_q;
  assign mbox.oCHUNK_IDX = idx_q;
  assign mbox.oPENDING   = (state_q == PEND);
  assign mbox.oOVERRUN   = overrun_q;
endmodule
